anotherworld_thread_scheduler: RTL

ANOTHERWORLD_THREAD_SCHEDULER -- requirements
Module: anotherworld_thread_scheduler

---
 rtl/anotherworld_thread_scheduler_pkg.sv | 28 ++
 rtl/anotherworld_thread_table.sv | 71 +++++++
 rtl/anotherworld_thread_scheduler.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/anotherworld_thread_scheduler_pkg.sv
// Shared constants and encodings for the Another World VM thread scheduler.
// The package is imported by the thread table and by the scheduler top.
package anotherworld_thread_scheduler_pkg;

  localparam int NUM_THREADS = 64;
  localparam int TID_W       = 6;
  localparam int PC_W        = 16;

  localparam logic [PC_W-1:0] PC_INACTIVE = 16'hFFFF;
  localparam logic [PC_W-1:0] PC_KILL     = 16'hFFFE;

  typedef enum logic [1:0] {
    CHAN_UNFREEZE = 2'd0,
    CHAN_FREEZE   = 2'd1,
    CHAN_KILL     = 2'd2,
    CHAN_NOP      = 2'd3
  } chan_type_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SCAN     = 3'd2,
    ST_DISPATCH = 3'd3,
    ST_RUN      = 3'd4,
    ST_DONE     = 3'd5
  } sched_state_e;

endpackage

// File: rtl/anotherworld_thread_table.sv
// Per-thread state (pc, req_pc, frozen, req_frozen) with one combinational read
// port and an arbitrated write side: setup commit, pc write, channel walk, setVec.
module anotherworld_thread_table
  import anotherworld_thread_scheduler_pkg::*;
#(
  parameter int NUM_THREADS = anotherworld_thread_scheduler_pkg::NUM_THREADS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [TID_W-1:0] rd_id,
  output logic [PC_W-1:0]  rd_pc,
  output logic             rd_frozen,
  input  logic             setup_en,
  input  logic [TID_W-1:0] setup_id,
  input  logic             pc_wr_en,
  input  logic [TID_W-1:0] pc_wr_id,
  input  logic [PC_W-1:0]  pc_wr_data,
  input  logic             chan_en,
  input  logic [TID_W-1:0] chan_id,
  input  logic [1:0]       chan_type,
  input  logic             setvec_en,
  input  logic [TID_W-1:0] setvec_id,
  input  logic [PC_W-1:0]  setvec_pc
);

  logic [PC_W-1:0]        pc_q     [NUM_THREADS];
  logic [PC_W-1:0]        req_pc_q [NUM_THREADS];
  logic [NUM_THREADS-1:0] frozen_q;
  logic [NUM_THREADS-1:0] req_frozen_q;

  assign rd_pc     = pc_q[rd_id];
  assign rd_frozen = frozen_q[rd_id];

  // Later assignments win: a request written in the same cycle that setup
  // consumes the old one survives, and setVec overrides a channel kill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        pc_q[i]     <= (i == 0) ? '0 : PC_INACTIVE;
        req_pc_q[i] <= PC_INACTIVE;
      end
      frozen_q     <= '0;
      req_frozen_q <= '0;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (setup_en && setup_id == TID_W'(i)) begin
          frozen_q[i] <= req_frozen_q[i];
          if (req_pc_q[i] != PC_INACTIVE) begin
            pc_q[i]     <= (req_pc_q[i] == PC_KILL) ? PC_INACTIVE : req_pc_q[i];
            req_pc_q[i] <= PC_INACTIVE;
          end
        end
        if (pc_wr_en && pc_wr_id == TID_W'(i)) begin
          pc_q[i] <= pc_wr_data;
        end
        if (chan_en && chan_id == TID_W'(i)) begin
          case (chan_type)
            CHAN_UNFREEZE: req_frozen_q[i] <= 1'b0;
            CHAN_FREEZE:   req_frozen_q[i] <= 1'b1;
            CHAN_KILL:     req_pc_q[i]     <= PC_KILL;
            default:       ;
          endcase
        end
        if (setvec_en && setvec_id == TID_W'(i)) begin
          req_pc_q[i] <= setvec_pc;
        end
      end
    end
  end

endmodule

// File: rtl/anotherworld_thread_scheduler.sv
// Frame scheduler: commits pending requests, then round-robins eligible threads
// to the CPU one at a time; a range walker applies updateChannel requests.
module anotherworld_thread_scheduler
  import anotherworld_thread_scheduler_pkg::*;
#(
  parameter int NUM_THREADS = anotherworld_thread_scheduler_pkg::NUM_THREADS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  output logic        busy,
  output logic        frame_done,
  output logic        run_valid,
  output logic [5:0]  run_thread,
  output logic [15:0] run_pc,
  input  logic        run_ready,
  input  logic        cpu_yield,
  input  logic [15:0] yield_pc,
  input  logic        yield_kill,
  input  logic        setvec_valid,
  input  logic [5:0]  setvec_thread,
  input  logic [15:0] setvec_pc,
  input  logic        chan_valid,
  input  logic [5:0]  chan_start,
  input  logic [5:0]  chan_end,
  input  logic [1:0]  chan_type,
  output logic        chan_ready
);

  localparam logic [TID_W-1:0] LAST_ID = TID_W'(NUM_THREADS - 1);

  sched_state_e     state_q, state_d;
  logic [TID_W-1:0] scan_id_q, scan_id_d;
  logic [TID_W-1:0] run_thread_d;
  logic [PC_W-1:0]  run_pc_d;
  logic [PC_W-1:0]  rd_pc;
  logic             rd_frozen;
  logic             eligible;
  logic             setup_en;
  logic             pc_wr_en;
  logic [PC_W-1:0]  pc_wr_data;

  logic             chan_busy_q;
  logic [TID_W-1:0] chan_id_q, chan_last_q;
  logic [1:0]       chan_type_q;
  logic             chan_accept;
  logic             chan_en;
  logic [TID_W-1:0] chan_wr_id;
  logic [1:0]       chan_wr_type;

  assign eligible = (rd_pc != PC_INACTIVE) && !rd_frozen;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      scan_id_q  <= '0;
      run_thread <= '0;
      run_pc     <= '0;
    end else begin
      state_q    <= state_d;
      scan_id_q  <= scan_id_d;
      run_thread <= run_thread_d;
      run_pc     <= run_pc_d;
    end
  end

  // scan_id_q doubles as the setup index and the scan pointer.
  always_comb begin
    state_d      = state_q;
    scan_id_d    = scan_id_q;
    run_thread_d = run_thread;
    run_pc_d     = run_pc;
    busy         = (state_q != ST_IDLE);
    frame_done   = 1'b0;
    run_valid    = 1'b0;
    setup_en     = 1'b0;
    pc_wr_en     = 1'b0;
    pc_wr_data   = yield_kill ? PC_INACTIVE : yield_pc;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d   = ST_SETUP;
          scan_id_d = '0;
        end
      end
      ST_SETUP: begin
        setup_en = 1'b1;
        if (scan_id_q == LAST_ID) begin
          state_d   = ST_SCAN;
          scan_id_d = '0;
        end else begin
          scan_id_d = scan_id_q + 1'b1;
        end
      end
      ST_SCAN: begin
        if (eligible) begin
          state_d      = ST_DISPATCH;
          run_thread_d = scan_id_q;
          run_pc_d     = rd_pc;
        end else if (scan_id_q == LAST_ID) begin
          state_d = ST_DONE;
        end else begin
          scan_id_d = scan_id_q + 1'b1;
        end
      end
      ST_DISPATCH: begin
        run_valid = 1'b1;
        if (run_ready) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cpu_yield) begin
          pc_wr_en = 1'b1;
          if (run_thread == LAST_ID) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_SCAN;
            scan_id_d = run_thread + 1'b1;
          end
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The first thread of a range is written in the acceptance cycle, so a
  // same-cycle setVec meets the channel write inside the table arbitration.
  assign chan_ready  = !chan_busy_q;
  assign chan_accept = chan_valid && chan_ready && (chan_end >= chan_start);

  always_comb begin
    chan_en      = chan_accept || chan_busy_q;
    chan_wr_id   = chan_busy_q ? chan_id_q : chan_start;
    chan_wr_type = chan_busy_q ? chan_type_q : chan_type;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chan_busy_q <= 1'b0;
      chan_id_q   <= '0;
      chan_last_q <= '0;
      chan_type_q <= '0;
    end else if (chan_accept) begin
      if (chan_end != chan_start) begin
        chan_busy_q <= 1'b1;
        chan_id_q   <= chan_start + 1'b1;
        chan_last_q <= chan_end;
        chan_type_q <= chan_type;
      end
    end else if (chan_busy_q) begin
      if (chan_id_q == chan_last_q) begin
        chan_busy_q <= 1'b0;
      end else begin
        chan_id_q <= chan_id_q + 1'b1;
      end
    end
  end

  anotherworld_thread_table #(
    .NUM_THREADS (NUM_THREADS)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .rd_id      (scan_id_q),
    .rd_pc      (rd_pc),
    .rd_frozen  (rd_frozen),
    .setup_en   (setup_en),
    .setup_id   (scan_id_q),
    .pc_wr_en   (pc_wr_en),
    .pc_wr_id   (run_thread),
    .pc_wr_data (pc_wr_data),
    .chan_en    (chan_en),
    .chan_id    (chan_wr_id),
    .chan_type  (chan_wr_type),
    .setvec_en  (setvec_valid),
    .setvec_id  (setvec_thread),
    .setvec_pc  (setvec_pc)
  );

endmodule
